vram_dualport: RTL and testbench

VRAM_DUALPORT -- requirements
Module: vram_dualport

---
 rtl/vram_dualport.sv | 179 +++++++++++++++++
 tb/tb_vram_dualport.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_dualport.sv
// Dual-port video RAM: a random-access DRAM-style port driven by RAS/CAS/WE/OE
// strobes sampled on MCLK, plus a serial access memory (SAM) streamed out by SC.
module vram_dualport #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          MCLK,
  input  logic          reset,
  input  logic          RAS,
  input  logic          CAS,
  input  logic          WE,
  input  logic          OE,
  input  logic          SC,
  input  logic          SE,
  input  logic [AW-1:0] AD,
  input  logic [DW-1:0] RD_i,
  output logic [DW-1:0] RD_o,
  output logic          RD_d,
  output logic [DW-1:0] SD_o,
  output logic          SD_d,
  output logic          QSF,
  output logic [1:0]    fsm_state
);

  localparam int NS = 1 << AW;
  localparam int RW = NS * DW;
  localparam int BW = $clog2(RW);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ROW_OPEN   = 2'd1;
  localparam logic [1:0] XFER_PEND  = 2'd2;
  localparam logic [1:0] CAS_ACTIVE = 2'd3;

  localparam logic [1:0] CYC_NORMAL     = 2'd0;
  localparam logic [1:0] CYC_MASKED     = 2'd1;
  localparam logic [1:0] CYC_READ_XFER  = 2'd2;
  localparam logic [1:0] CYC_WRITE_XFER = 2'd3;

  // One array entry is a whole row, so transfers are single row-wide copies.
  logic [RW-1:0] mem [NS];
  logic [RW-1:0] sam;

  logic          ras_q, cas_q, we_q, oe_q, sc_q, armed;
  logic [1:0]    state, cyc;
  logic [AW-1:0] row, col, ptr;
  logic [DW-1:0] mask;
  logic          xfer_done;

  logic          ras_fall, ras_rise, cas_fall, cas_rise, we_fall, oe_rise, sc_rise;
  logic          row_open, rw_cycle, early_wr, late_wr, wr_en, rd_xfer, wr_xfer;
  logic [AW-1:0] wr_col, rd_col;
  logic [BW-1:0] wr_base, rd_base, sd_base;
  logic [DW-1:0] wr_mask, cur_word;

  // armed is low for the first MCLK after reset so strobes already asserted
  // while in reset are not mistaken for fresh edges.
  assign ras_fall = armed & ras_q & ~RAS;
  assign ras_rise = armed & ~ras_q & RAS;
  assign cas_fall = armed & cas_q & ~CAS;
  assign cas_rise = armed & ~cas_q & CAS;
  assign we_fall  = armed & we_q & ~WE;
  assign oe_rise  = armed & ~oe_q & OE;
  assign sc_rise  = armed & ~sc_q & SC;

  assign row_open = (state != IDLE) && !RAS;
  assign rw_cycle = (cyc == CYC_NORMAL) || (cyc == CYC_MASKED);
  assign early_wr = cas_fall & row_open & rw_cycle & ~WE;
  assign late_wr  = we_fall & row_open & rw_cycle & ~CAS & (state == CAS_ACTIVE);
  assign wr_en    = early_wr | late_wr;
  assign rd_xfer  = oe_rise & row_open & (cyc == CYC_READ_XFER) & ~xfer_done;
  assign wr_xfer  = cas_fall & row_open & (cyc == CYC_WRITE_XFER);

  assign wr_col   = early_wr ? AD : col;
  assign rd_col   = (cas_fall && row_open) ? AD : col;
  assign wr_base  = BW'(wr_col) * BW'(DW);
  assign rd_base  = BW'(rd_col) * BW'(DW);
  assign sd_base  = BW'(ptr) * BW'(DW);
  assign wr_mask  = (cyc == CYC_MASKED) ? mask : '1;
  assign cur_word = mem[row][wr_base +: DW];

  assign RD_d      = !(!RAS && !CAS && !OE && WE && (state != IDLE) && rw_cycle);
  assign SD_d      = SE;
  assign QSF       = ptr[AW-1];
  assign fsm_state = state;

  // Storage is never reset; every write enable already requires an open row,
  // and reset holds the state machine in IDLE.
  always_ff @(posedge MCLK) begin
    if (wr_xfer) begin
      mem[row] <= sam;
    end else if (wr_en) begin
      mem[row][wr_base +: DW] <= (cur_word & ~wr_mask) | (RD_i & wr_mask);
    end
    if (rd_xfer) begin
      sam <= mem[row];
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      ras_q     <= 1'b1;
      cas_q     <= 1'b1;
      we_q      <= 1'b1;
      oe_q      <= 1'b1;
      sc_q      <= 1'b0;
      armed     <= 1'b0;
      state     <= IDLE;
      cyc       <= CYC_NORMAL;
      row       <= '0;
      col       <= '0;
      mask      <= '0;
      ptr       <= '0;
      xfer_done <= 1'b0;
      RD_o      <= '0;
      SD_o      <= '0;
    end else begin
      ras_q <= RAS;
      cas_q <= CAS;
      we_q  <= WE;
      oe_q  <= OE;
      sc_q  <= SC;
      armed <= 1'b1;

      if (ras_fall) begin
        row       <= AD;
        xfer_done <= 1'b0;
        case ({OE, WE})
          2'b00:   cyc <= CYC_WRITE_XFER;
          2'b01:   cyc <= CYC_READ_XFER;
          2'b10: begin
            cyc  <= CYC_MASKED;
            mask <= RD_i;
          end
          default: cyc <= CYC_NORMAL;
        endcase
      end

      if (cas_fall && row_open) begin
        col <= AD;
      end

      if (rd_xfer) begin
        xfer_done <= 1'b1;
      end

      // A transfer in the same MCLK as an SC edge wins; no increment.
      if (rd_xfer) begin
        ptr <= col;
      end else if (wr_xfer) begin
        ptr <= AD;
      end else if (sc_rise) begin
        ptr <= ptr + 1'b1;
      end

      if (ras_rise) begin
        state <= IDLE;
      end else if (rd_xfer || wr_xfer) begin
        state <= XFER_PEND;
      end else begin
        case (state)
          IDLE:       if (ras_fall) state <= ROW_OPEN;
          ROW_OPEN:   if (!RAS && !CAS) state <= CAS_ACTIVE;
          CAS_ACTIVE: if (cas_rise) state <= ROW_OPEN;
          XFER_PEND:  state <= CAS ? ROW_OPEN : CAS_ACTIVE;
          default:    state <= IDLE;
        endcase
      end

      if ((cas_fall && row_open) || (state == CAS_ACTIVE)) begin
        RD_o <= mem[row][rd_base +: DW];
      end

      if (!SE) begin
        SD_o <= sam[sd_base +: DW];
      end
    end
  end

endmodule

// File: tb/tb_vram_dualport.sv
// Bench for vram_dualport: strobe-level driver tasks, a reference array/SAM
// model, and an expected-value queue popped when the DUT output is sampled.
module tb_vram_dualport;

  logic       MCLK;
  logic       reset;
  logic       RAS, CAS, WE, OE, SC, SE;
  logic [7:0] AD;
  logic [7:0] RD_i;
  logic [7:0] RD_o;
  logic       RD_d;
  logic [7:0] SD_o;
  logic       SD_d;
  logic       QSF;
  logic [1:0] fsm_state;

  vram_dualport #(.DW(8), .AW(8)) dut (
    .MCLK(MCLK), .reset(reset),
    .RAS(RAS), .CAS(CAS), .WE(WE), .OE(OE), .SC(SC), .SE(SE),
    .AD(AD), .RD_i(RD_i),
    .RD_o(RD_o), .RD_d(RD_d), .SD_o(SD_o), .SD_d(SD_d), .QSF(QSF),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] ref_sam [0:255];
  logic [7:0] ref_ptr;

  // driver tasks
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic pins_idle();
    RAS = 1'b1; CAS = 1'b1; WE = 1'b1; OE = 1'b1; SC = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d,
                            input logic masked, input logic [7:0] m);
    RAS = 1'b0; AD = r; OE = 1'b1; WE = masked ? 1'b0 : 1'b1; RD_i = m;
    tick();
    AD = c; CAS = 1'b0; WE = 1'b0; RD_i = d;
    tick();
    if (masked) ref_mem[{r, c}] = (ref_mem[{r, c}] & ~m) | (d & m);
    else        ref_mem[{r, c}] = d;
    CAS = 1'b1; WE = 1'b1;
    tick();
    RAS = 1'b1;
    tick();
    tick();
  endtask

  task automatic write_late(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
    RAS = 1'b0; AD = r; OE = 1'b1; WE = 1'b1;
    tick();
    AD = c; CAS = 1'b0;
    tick();
    WE = 1'b0; RD_i = d;
    tick();
    ref_mem[{r, c}] = d;
    CAS = 1'b1; WE = 1'b1;
    tick();
    RAS = 1'b1;
    tick();
    tick();
  endtask

  task automatic read_word(input logic [7:0] r, input logic [7:0] c,
                           output logic [7:0] data, output logic dis);
    RAS = 1'b0; AD = r; OE = 1'b1; WE = 1'b1;
    tick();
    AD = c; CAS = 1'b0; OE = 1'b0;
    tick();
    data = RD_o;
    dis  = RD_d;
    CAS = 1'b1; OE = 1'b1;
    tick();
    RAS = 1'b1;
    tick();
    tick();
  endtask

  task automatic read_xfer(input logic [7:0] r, input logic [7:0] c, input logic sc_same,
                           output logic q_obs, output logic [7:0] s_obs);
    RAS = 1'b0; AD = r; OE = 1'b0; WE = 1'b1;
    tick();
    AD = c; CAS = 1'b0;
    tick();
    OE = 1'b1; SC = sc_same;
    tick();
    for (int i = 0; i < 256; i++) ref_sam[i] = ref_mem[{r, 8'(i)}];
    ref_ptr = c;
    q_obs = QSF;
    SC = 1'b0; CAS = 1'b1;
    tick();
    s_obs = SD_o;
    RAS = 1'b1;
    tick();
    tick();
  endtask

  task automatic write_xfer(input logic [7:0] r, input logic [7:0] c, output logic dis);
    RAS = 1'b0; AD = r; OE = 1'b0; WE = 1'b0;
    tick();
    AD = c; CAS = 1'b0; WE = 1'b1;
    tick();
    dis = RD_d;
    for (int i = 0; i < 256; i++) ref_mem[{r, 8'(i)}] = ref_sam[i];
    ref_ptr = c;
    CAS = 1'b1; OE = 1'b1;
    tick();
    RAS = 1'b1;
    tick();
    tick();
  endtask

  task automatic sc_pulse();
    SC = 1'b1;
    tick();
    ref_ptr = ref_ptr + 8'd1;
    SC = 1'b0;
    tick();
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1; SE = 1'b1; AD = '0; RD_i = '0;
    pins_idle();
    tick();
    tick();
    checks++; if (RD_o !== 8'h00) begin failures++; $display("FAIL reset_rd_o: got %h expected 00", RD_o); end
    checks++; if (SD_o !== 8'h00) begin failures++; $display("FAIL reset_sd_o: got %h expected 00", SD_o); end
    checks++; if (RD_d !== 1'b1) begin failures++; $display("FAIL reset_rd_d: got %b expected 1", RD_d); end
    checks++; if (QSF !== 1'b0) begin failures++; $display("FAIL reset_qsf: got %b expected 0", QSF); end
    checks++; if (SD_d !== 1'b1) begin failures++; $display("FAIL reset_sd_d: got %b expected 1", SD_d); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    reset = 1'b0;
    tick();
    SE = 1'b0;
    #1;
    checks++; if (SD_d !== 1'b0) begin failures++; $display("FAIL sd_d_follows_se: got %b expected 0", SD_d); end
    ref_ptr = 8'h00;
    tick();
  endtask

  task automatic test_normal();
    logic [7:0] d;
    logic       dis;
    write_word(8'h12, 8'h34, 8'hA5, 1'b0, 8'h00);
    exp_q.push_back(ref_mem[16'h1234]);
    read_word(8'h12, 8'h34, d, dis);
    checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL normal_read: got %h expected a5", d); end
    checks++; if (dis !== 1'b0) begin failures++; $display("FAIL normal_rd_d: got %b expected 0", dis); end
    write_late(8'h77, 8'h01, 8'hC3);
    exp_q.push_back(ref_mem[16'h7701]);
    read_word(8'h77, 8'h01, d, dis);
    checks++; if (d !== exp_q.pop_front()) begin failures++; $display("FAIL late_write_read: got %h expected c3", d); end
  endtask

  task automatic test_masked();
    logic [7:0] d;
    logic       dis;
    logic [7:0] e;
    write_word(8'h20, 8'h00, 8'h00, 1'b0, 8'h00);
    write_word(8'h20, 8'h00, 8'hFF, 1'b1, 8'h0F);
    exp_q.push_back(ref_mem[16'h2000]);
    read_word(8'h20, 8'h00, d, dis);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL masked_0f: got %h expected %h", d, e); end
    write_word(8'h20, 8'h00, 8'h3C, 1'b1, 8'hF0);
    exp_q.push_back(ref_mem[16'h2000]);
    read_word(8'h20, 8'h00, d, dis);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL masked_f0: got %h expected %h", d, e); end
  endtask

  task automatic test_read_xfer();
    logic       q;
    logic [7:0] s;
    logic [7:0] e;
    for (int i = 0; i < 256; i++) begin
      write_word(8'h12, 8'(i), 8'(i), 1'b0, 8'h00);
      write_word(8'h40, 8'(i), ~8'(i), 1'b0, 8'h00);
    end
    exp_q.push_back(ref_mem[16'h12FE]);
    read_xfer(8'h12, 8'hFE, 1'b0, q, s);
    e = exp_q.pop_front();
    checks++; if (q !== 1'b1) begin failures++; $display("FAIL rx_qsf_start: got %b expected 1", q); end
    checks++; if (s !== e) begin failures++; $display("FAIL rx_sd_start: got %h expected %h", s, e); end
    for (int k = 0; k < 3; k++) begin
      sc_pulse();
      exp_q.push_back(ref_sam[ref_ptr]);
      e = exp_q.pop_front();
      checks++; if (SD_o !== e) begin failures++; $display("FAIL rx_sd_step%0d: got %h expected %h", k, SD_o, e); end
      checks++; if (QSF !== ref_ptr[7]) begin failures++; $display("FAIL rx_qsf_step%0d: got %b expected %b", k, QSF, ref_ptr[7]); end
    end
    SE = 1'b1;
    exp_q.push_back(ref_sam[ref_ptr]);
    sc_pulse();
    e = exp_q.pop_front();
    checks++; if (SD_o !== e) begin failures++; $display("FAIL sd_hold_se: got %h expected %h", SD_o, e); end
    checks++; if (SD_d !== 1'b1) begin failures++; $display("FAIL sd_d_high: got %b expected 1", SD_d); end
    SE = 1'b0;
    tick();
    exp_q.push_back(ref_sam[ref_ptr]);
    e = exp_q.pop_front();
    checks++; if (SD_o !== e) begin failures++; $display("FAIL sd_resume: got %h expected %h", SD_o, e); end
  endtask

  task automatic test_write_xfer();
    logic       dis;
    logic [7:0] d;
    logic [7:0] e;
    write_xfer(8'h40, 8'h10, dis);
    checks++; if (dis !== 1'b1) begin failures++; $display("FAIL wx_rd_d: got %b expected 1", dis); end
    checks++; if (QSF !== ref_ptr[7]) begin failures++; $display("FAIL wx_qsf: got %b expected %b", QSF, ref_ptr[7]); end
    exp_q.push_back(ref_sam[ref_ptr]);
    e = exp_q.pop_front();
    checks++; if (SD_o !== e) begin failures++; $display("FAIL wx_sd: got %h expected %h", SD_o, e); end
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(ref_mem[{8'h40, 8'(i)}]);
      read_word(8'h40, 8'(i), d, dis);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL wx_row40_col%0d: got %h expected %h", i, d, e); end
    end
  endtask

  task automatic test_sc_collision();
    logic       q;
    logic [7:0] s;
    logic [7:0] e;
    exp_q.push_back(ref_mem[16'h1280]);
    read_xfer(8'h12, 8'h80, 1'b1, q, s);
    e = exp_q.pop_front();
    checks++; if (q !== 1'b1) begin failures++; $display("FAIL coll_qsf: got %b expected 1", q); end
    checks++; if (s !== e) begin failures++; $display("FAIL coll_sd: got %h expected %h", s, e); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    logic       dis;
    logic [7:0] e;
    RAS = 1'b0; AD = 8'h12; OE = 1'b1; WE = 1'b1;
    tick();
    AD = 8'h55; CAS = 1'b0; RD_i = 8'h3C;
    tick();
    reset = 1'b1;
    #1;
    ref_ptr = 8'h00;
    checks++; if (RD_d !== 1'b1) begin failures++; $display("FAIL abort_rd_d: got %b expected 1", RD_d); end
    checks++; if (QSF !== 1'b0) begin failures++; $display("FAIL abort_qsf: got %b expected 0", QSF); end
    checks++; if (RD_o !== 8'h00) begin failures++; $display("FAIL abort_rd_o: got %h expected 00", RD_o); end
    tick();
    reset = 1'b0;
    tick();
    tick();
    OE = 1'b0;
    #1;
    checks++; if (RD_d !== 1'b1) begin failures++; $display("FAIL post_reset_rd_d: got %b expected 1", RD_d); end
    OE = 1'b1; WE = 1'b0;
    tick();
    tick();
    pins_idle();
    tick();
    tick();
    exp_q.push_back(ref_mem[16'h1255]);
    read_word(8'h12, 8'h55, d, dis);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL abort_no_write_55: got %h expected %h", d, e); end
    exp_q.push_back(ref_mem[16'h1200]);
    read_word(8'h12, 8'h00, d, dis);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL abort_no_write_00: got %h expected %h", d, e); end
  endtask

  task automatic test_xfer_abort();
    logic [7:0] e;
    RAS = 1'b0; AD = 8'h77; OE = 1'b0; WE = 1'b1;
    tick();
    AD = 8'h01; CAS = 1'b0;
    tick();
    CAS = 1'b1;
    tick();
    RAS = 1'b1;
    tick();
    OE = 1'b1;
    tick();
    tick();
    exp_q.push_back(ref_sam[ref_ptr]);
    e = exp_q.pop_front();
    checks++; if (SD_o !== e) begin failures++; $display("FAIL ras_before_oe_sd: got %h expected %h", SD_o, e); end
    checks++; if (QSF !== ref_ptr[7]) begin failures++; $display("FAIL ras_before_oe_qsf: got %b expected %b", QSF, ref_ptr[7]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rows [8];
    logic [7:0] d;
    logic       dis;
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      rows[i] = 8'($urandom_range(0, 255));
      write_word(rows[i], 8'(8'hC0 + i), 8'($urandom_range(0, 255)), 1'b0, 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ref_mem[{rows[i], 8'(8'hC0 + i)}]);
      read_word(rows[i], 8'(8'hC0 + i), d, dis);
      e = exp_q.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL b2b_read%0d: got %h expected %h", i, d, e); end
      checks++; if (dis !== 1'b0) begin failures++; $display("FAIL b2b_rd_d%0d: got %b expected 0", i, dis); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_masked();
    test_read_xfer();
    test_write_xfer();
    test_sc_collision();
    test_reset_abort();
    test_xfer_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
